// File: rtl/mic_conditioner.sv
// mic_conditioner
//   Microphone front-end: optional DC-offset removal, selectable bit-window
//   gain with symmetric saturation, clip indicator/counter and a decaying
//   peak-level meter.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active low
//   mic        signed input sample (w_in bits), captured when mic_valid is high
//   mic_valid  one-cycle input strobe
//   gain       window select, clamped to max_gain
//   dc_en      enables DC removal (tracker cleared while low)
//   cnt_clr    synchronous clear of clip_cnt, wins over an increment
//   out        conditioned signed sample (w_out bits), held between strobes
//   out_valid  one-cycle strobe, two clocks after mic_valid
//   clip       set with out_valid when the sample saturated
//   clip_led   stretched clip indicator (hold_ms)
//   clip_cnt   saturating count of clipped samples
//   level_led  thermometer peak meter
module mic_conditioner #(
   parameter int clk_mhz  = 50,
   parameter int w_in     = 24,
   parameter int w_out    = 11,
   parameter int max_gain = w_in - w_out,
   parameter int w_gain   = $clog2(max_gain + 1),
   parameter int dc_k     = 4,
   parameter int hold_ms  = 100,
   parameter int decay_us = 1000,
   parameter int w_led    = 8,
   parameter int w_cnt    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [w_in-1:0]  mic,
   input  logic                    mic_valid,
   input  logic [w_gain-1:0]       gain,
   input  logic                    dc_en,
   input  logic                    cnt_clr,
   output logic signed [w_out-1:0] out,
   output logic                    out_valid,
   output logic                    clip,
   output logic                    clip_led,
   output logic [w_cnt-1:0]        clip_cnt,
   output logic [w_led-1:0]        level_led
);

   localparam int w_c       = w_in + 1;
   localparam int w_acc     = w_in + dc_k + 1;
   localparam int w_mag     = w_out - 1;
   localparam int w_sh      = $clog2(w_c);
   localparam int hold_cyc  = clk_mhz * 1000 * hold_ms;
   localparam int w_hold    = $clog2(hold_cyc + 1);
   localparam int decay_cyc = clk_mhz * decay_us;
   localparam int w_tick    = (decay_cyc > 1) ? $clog2(decay_cyc) : 1;

   localparam logic signed [w_out-1:0] sat_pos   = {1'b0, {(w_out-1){1'b1}}};
   localparam logic signed [w_out-1:0] sat_neg   = {1'b1, {(w_out-1){1'b0}}};
   localparam logic [w_gain-1:0]       gain_max  = w_gain'(max_gain);
   localparam logic [w_hold-1:0]       hold_load = w_hold'(hold_cyc);
   localparam logic [w_hold-1:0]       hold_one  = {{(w_hold-1){1'b0}}, 1'b1};
   localparam logic [w_tick-1:0]       tick_last = w_tick'(decay_cyc - 1);
   localparam logic [w_tick-1:0]       tick_one  = {{(w_tick-1){1'b0}}, 1'b1};
   localparam logic [w_mag-1:0]        mag_one   = {{(w_mag-1){1'b0}}, 1'b1};
   localparam logic [w_cnt-1:0]        cnt_one   = {{(w_cnt-1){1'b0}}, 1'b1};

   // Meter threshold for LED idx: (idx+1)/(w_led+1) of full scale.
   function automatic logic [w_mag:0] thr(input int idx);
      thr = (w_mag + 1)'(((idx + 1) * (32'sd1 <<< (w_out - 1))) / (w_led + 1));
   endfunction

   // Stage 1 state
   logic signed [w_acc-1:0] acc_r;
   logic signed [w_c-1:0]   c_r;
   logic                    v1_r;
   logic signed [w_c-1:0]   c_next_s;
   logic signed [w_acc-1:0] acc_next_s;

   // Stage 2 state
   logic [w_gain-1:0]       g_s;
   logic [w_sh-1:0]         guard_sh_s;
   logic [w_sh-1:0]         win_sh_s;
   logic signed [w_c-1:0]   guard_s;
   logic                    fits_s;
   logic signed [w_out-1:0] out_next_s;
   logic signed [w_out-1:0] out_r;
   logic                    out_valid_r;
   logic                    clip_r;

   // Clip indicator / counter state
   logic [w_hold-1:0]       hold_r;
   logic                    clip_led_r;
   logic [w_cnt-1:0]        clip_cnt_r;

   // Peak meter state
   logic [w_tick-1:0]       tick_cnt_r;
   logic                    tick_s;
   logic [w_mag-1:0]        mag_s;
   logic [w_mag-1:0]        decayed_s;
   logic [w_mag-1:0]        peak_next_s;
   logic [w_mag-1:0]        peak_r;
   logic [w_led-1:0]        level_r;

   // Stage-1 DC subtraction and tracker update (acc holds 2^dc_k times the offset)
   always_comb begin
      c_next_s   = {mic[w_in-1], mic};
      acc_next_s = {w_acc{1'b0}};
      if (dc_en) begin
         c_next_s   = {mic[w_in-1], mic} - w_c'(acc_r >>> dc_k);
         acc_next_s = acc_r + {{dc_k{c_next_s[w_c-1]}}, c_next_s};
      end else begin
         c_next_s   = {mic[w_in-1], mic};
         acc_next_s = {w_acc{1'b0}};
      end
   end

   // Stage-1 registers: centred sample, DC accumulator, valid pipe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r <= {w_acc{1'b0}};
         c_r   <= {w_c{1'b0}};
         v1_r  <= 1'b0;
      end else begin
         v1_r <= mic_valid;
         if (mic_valid) begin
            acc_r <= acc_next_s;
            c_r   <= c_next_s;
         end else begin
            acc_r <= acc_r;
            c_r   <= c_r;
         end
      end
   end

   // Stage-2 window select: guard bits c[w_in : w_in-1-g] equal means the
   // value sign-extends from the window top, i.e. c >>> (w_in-1-g) is 0 or -1.
   always_comb begin
      if (gain > gain_max) begin
         g_s = gain_max;
      end else begin
         g_s = gain;
      end
      guard_sh_s = w_sh'(w_in - 1) - w_sh'(g_s);
      win_sh_s   = w_sh'(max_gain) - w_sh'(g_s);
      guard_s    = c_r >>> guard_sh_s;
      fits_s     = (guard_s == {w_c{1'b0}}) || (guard_s == {w_c{1'b1}});
      if (fits_s) begin
         out_next_s = w_out'(c_r >>> win_sh_s);
      end else if (c_r[w_in]) begin
         out_next_s = sat_neg;
      end else begin
         out_next_s = sat_pos;
      end
   end

   // Stage-2 output registers; out and clip hold between strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= 1'b0;
         out_r       <= {w_out{1'b0}};
         clip_r      <= 1'b0;
      end else begin
         out_valid_r <= v1_r;
         if (v1_r) begin
            out_r  <= out_next_s;
            clip_r <= ~fits_s;
         end else begin
            out_r  <= out_r;
            clip_r <= clip_r;
         end
      end
   end

   // Retriggerable clip hold: LED stays lit for exactly hold_cyc clocks
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_r     <= {w_hold{1'b0}};
         clip_led_r <= 1'b0;
      end else if (out_valid_r && clip_r) begin
         hold_r     <= hold_load;
         clip_led_r <= 1'b1;
      end else if (hold_r != {w_hold{1'b0}}) begin
         hold_r     <= hold_r - hold_one;
         clip_led_r <= (hold_r != hold_one);
      end else begin
         hold_r     <= hold_r;
         clip_led_r <= 1'b0;
      end
   end

   // Saturating clip counter; clear has priority over increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clip_cnt_r <= {w_cnt{1'b0}};
      end else if (cnt_clr) begin
         clip_cnt_r <= {w_cnt{1'b0}};
      end else if (out_valid_r && clip_r && (clip_cnt_r != {w_cnt{1'b1}})) begin
         clip_cnt_r <= clip_cnt_r + cnt_one;
      end else begin
         clip_cnt_r <= clip_cnt_r;
      end
   end

   // Free-running decay tick divider
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt_r <= {w_tick{1'b0}};
      end else if (tick_s) begin
         tick_cnt_r <= {w_tick{1'b0}};
      end else begin
         tick_cnt_r <= tick_cnt_r + tick_one;
      end
   end

   // Peak update: |out| (clamped so -full-scale fits), decay first, then max
   always_comb begin
      tick_s = (tick_cnt_r == tick_last);
      if (out_r == sat_neg) begin
         mag_s = {w_mag{1'b1}};
      end else if (out_r[w_out-1]) begin
         mag_s = w_mag'(-out_r);
      end else begin
         mag_s = w_mag'(out_r);
      end
      if (tick_s && (peak_r != {w_mag{1'b0}})) begin
         decayed_s = peak_r - ((peak_r >> 3'd3) | mag_one);
      end else if (tick_s) begin
         decayed_s = {w_mag{1'b0}};
      end else begin
         decayed_s = peak_r;
      end
      if (out_valid_r && (mag_s > decayed_s)) begin
         peak_next_s = mag_s;
      end else begin
         peak_next_s = decayed_s;
      end
   end

   // Peak register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         peak_r <= {w_mag{1'b0}};
      end else begin
         peak_r <= peak_next_s;
      end
   end

   // Thermometer LEDs follow peak one clock later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_r <= {w_led{1'b0}};
      end else begin
         for (int i = 0; i < w_led; i++) begin
            level_r[i] <= ({1'b0, peak_r} >= thr(i));
         end
      end
   end

   assign out       = out_r;
   assign out_valid = out_valid_r;
   assign clip      = clip_r;
   assign clip_led  = clip_led_r;
   assign clip_cnt  = clip_cnt_r;
   assign level_led = level_r;

endmodule

// File: tb/tb_mic_conditioner.sv
`timescale 1ns/1ps
// Scoreboard bench for mic_conditioner. Datapath parameters are defaults;
// time constants are shortened (clk_mhz=1, hold_ms=1, decay_us=10).
module tb_mic_conditioner;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic signed [23:0] mic = 24'sd0;
   logic               mic_valid = 1'b0;
   logic [3:0]         gain = 4'd6;
   logic               dc_en = 1'b0;
   logic               cnt_clr = 1'b0;
   logic signed [10:0] out;
   logic               out_valid;
   logic               clip;
   logic               clip_led;
   logic [15:0]        clip_cnt;
   logic [7:0]         level_led;

   mic_conditioner #(.clk_mhz(1), .hold_ms(1), .decay_us(10)) dut (
      .clk(clk), .rst(rst), .mic(mic), .mic_valid(mic_valid), .gain(gain),
      .dc_en(dc_en), .cnt_clr(cnt_clr), .out(out), .out_valid(out_valid),
      .clip(clip), .clip_led(clip_led), .clip_cnt(clip_cnt), .level_led(level_led)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic signed [10:0] e_out;
      logic               e_clip;
      int                 due;
      bit                 chk;
   } exp_t;

   exp_t               sb_q[$];
   exp_t               mon_e;
   logic signed [10:0] dc_outs[$];
   bit                 dc_clip_seen = 1'b0;
   int                 checks = 0;
   int                 errors = 0;
   int                 last_cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per out_valid and checks latency and data
   always @(negedge clk) begin
      if (rst && out_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid actual out=%0d expected none (cyc %0d)", out, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            if (cyc != mon_e.due) begin
               errors++;
               $display("FAIL latency actual cyc=%0d expected cyc=%0d", cyc, mon_e.due);
            end else if (mon_e.chk && (out !== mon_e.e_out || clip !== mon_e.e_clip)) begin
               errors++;
               $display("FAIL sample actual out=%0d clip=%0b expected out=%0d clip=%0b (cyc %0d)",
                        out, clip, mon_e.e_out, mon_e.e_clip, cyc);
            end else if (!mon_e.chk) begin
               dc_outs.push_back(out);
               if (clip !== 1'b0) dc_clip_seen = 1'b1;
            end
         end
      end
   end

   task automatic send(input logic signed [23:0] m, input int n,
                       input logic signed [10:0] eo, input logic ec, input bit chk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mic       = m;
         mic_valid = 1'b1;
         last_cyc  = cyc;
         sb_q.push_back('{e_out: eo, e_clip: ec, due: cyc + 2, chk: chk});
      end
      @(negedge clk);
      mic_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   int          a, b, viol, k, m_ticks, p, z;
   logic [7:0]  prev_led, cur_led;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out", out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_clip", clip, 0);
      check("rst_clip_led", clip_led, 0);
      check("rst_clip_cnt", clip_cnt, 0);
      check("rst_level", level_led, 0);
      rst = 1'b1;
      idle(2);

      // Normal window: 1152 >> 7 = 9
      gain = 4'd6;
      send(24'sd1152, 1, 11'sd9, 1'b0, 1'b1);
      idle(3);
      check("t1_clip_cnt", clip_cnt, 0);

      // Saturation both ways
      send(24'sd262144, 1, 11'sd1023, 1'b1, 1'b1);
      send(-24'sd262145, 1, -11'sd1024, 1'b1, 1'b1);
      idle(3);
      check("t2_clip_cnt", clip_cnt, 2);
      check("t2_clip_led", clip_led, 1);

      // Gain extremes, 15 clamps to 13
      gain = 4'd0;
      send(24'sd8388607, 1, 11'sd1023, 1'b0, 1'b1);
      idle(3);
      gain = 4'd15;
      send(24'sd1000, 1, 11'sd1000, 1'b0, 1'b1);
      idle(3);

      // Clip LED hold (1000 clocks) and retrigger at +500
      k = 0;
      while (clip_led !== 1'b0 && k < 1500) begin @(negedge clk); k++; end
      check("hold_settle", clip_led, 0);
      gain = 4'd6;
      send(24'sd262144, 1, 11'sd1023, 1'b1, 1'b1);
      a = last_cyc;
      wait_cyc(a + 2);
      check("led_before_rise", clip_led, 0);
      wait_cyc(a + 3);
      check("led_rise", clip_led, 1);
      wait_cyc(a + 500);
      send(24'sd262144, 1, 11'sd1023, 1'b1, 1'b1);
      b = last_cyc;
      wait_cyc(a + 1003);
      check("led_extended", clip_led, 1);
      wait_cyc(b + 1002);
      check("led_last_hold", clip_led, 1);
      wait_cyc(b + 1003);
      check("led_fall", clip_led, 0);

      // DC removal: 1000, 938, ... converging to 0
      gain  = 4'd13;
      dc_en = 1'b1;
      send(24'sd1000, 400, 11'sd0, 1'b0, 1'b0);
      idle(4);
      check("dc_count", dc_outs.size(), 400);
      if (dc_outs.size() >= 2) begin
         check("dc_first", dc_outs[0], 1000);
         check("dc_second", dc_outs[1], 938);
         viol = 0;
         for (int i = 1; i < dc_outs.size(); i++) if (dc_outs[i] > dc_outs[i-1]) viol++;
         check("dc_monotone", viol, 0);
         check("dc_final", dc_outs[dc_outs.size()-1], 0);
      end
      check("dc_clip", dc_clip_seen, 0);
      dc_en = 1'b0;
      send(24'sd1000, 1, 11'sd1000, 1'b0, 1'b1);
      idle(3);

      // Peak meter: decay steps until peak drops below the first threshold (113)
      m_ticks = 0;
      p = 1023;
      while (p >= 113) begin p = p - ((p >> 3) | 1); m_ticks++; end
      k = 0;
      while (level_led !== 8'd0 && k < 3000) begin @(negedge clk); k++; end
      check("meter_settle", level_led, 0);
      send(24'sd8388607, 1, 11'sd1023, 1'b1, 1'b1);
      a = last_cyc;
      wait_cyc(a + 3);
      check("meter_before", level_led, 0);
      wait_cyc(a + 4);
      check("meter_full", level_led, 8'hFF);
      prev_led = level_led;
      viol = 0;
      k = 0;
      while (level_led !== 8'd0 && k < 3000) begin
         @(negedge clk);
         k++;
         cur_led = level_led;
         if (($countones(cur_led) > $countones(prev_led)) || ((cur_led & (cur_led + 8'd1)) != 8'd0)) viol++;
         prev_led = cur_led;
      end
      z = cyc;
      check("meter_monotone", viol, 0);
      check("meter_off", level_led, 0);
      checks++;
      if (z < a + 5 + 10 * (m_ticks - 1) || z > a + 14 + 10 * (m_ticks - 1)) begin
         errors++;
         $display("FAIL meter_decay_time actual cyc=%0d expected %0d..%0d",
                  z, a + 5 + 10 * (m_ticks - 1), a + 14 + 10 * (m_ticks - 1));
      end

      // cnt_clr coincident with a clipped output
      send(24'sd8388607, 1, 11'sd1023, 1'b1, 1'b1);
      a = last_cyc;
      wait_cyc(a + 2);
      check("cnt_before_clr", clip_cnt, 5);
      cnt_clr = 1'b1;
      wait_cyc(a + 3);
      cnt_clr = 1'b0;
      check("cnt_clr_wins", clip_cnt, 0);

      // Counter saturation under continuous clipping
      send(24'sd8388607, 65540, 11'sd1023, 1'b1, 1'b1);
      idle(4);
      check("cnt_saturate", clip_cnt, 65535);

      // Reset mid-pipeline: sample dropped, outputs cleared immediately
      @(negedge clk);
      mic       = 24'sd8388607;
      mic_valid = 1'b1;
      @(negedge clk);
      mic_valid = 1'b0;
      rst       = 1'b0;
      #1;
      check("mid_rst_out", out, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_clip", clip, 0);
      check("mid_rst_clip_led", clip_led, 0);
      check("mid_rst_clip_cnt", clip_cnt, 0);
      check("mid_rst_level", level_led, 0);
      viol = 0;
      repeat (3) begin
         @(negedge clk);
         if (out !== 11'sd0 || out_valid !== 1'b0 || clip !== 1'b0 || clip_led !== 1'b0 ||
             clip_cnt !== 16'd0 || level_led !== 8'd0) viol++;
      end
      check("rst_hold_zero", viol, 0);
      rst = 1'b1;
      idle(4);
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_clip_cnt", clip_cnt, 0);
      check("post_rst_clip_led", clip_led, 0);
      gain = 4'd6;
      send(24'sd1152, 1, 11'sd9, 1'b0, 1'b1);
      idle(3);

      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mic_conditioner.md
# mic_conditioner

Parametrised microphone front-end that turns the raw signed PDM/I2S sample stream into a narrow signed sample for downstream analysers such as the spectrum display and pitch detectors. It provides:

- optional DC-offset removal;
- run-time selectable gain (bit-window position) with symmetric saturation;
- a retriggerable clip indicator and a saturating clip counter;
- a decaying peak-level meter for LEDs.

It sits between the board microphone interface and any lab DSP block, replacing ad-hoc slice-and-saturate logic in lab tops.

## Interface

Parameters:

- `clk_mhz`, 50: clock frequency in MHz; used for time constants.
- `w_in`, 24: input sample width, signed.
- `w_out`, 11: output sample width, signed; requires `w_out <= w_in`.
- `max_gain`, `w_in - w_out`: largest legal gain code.
- `w_gain`, `$clog2(max_gain + 1)`: gain port width.
- `dc_k`, 4: DC tracker time constant, 2^`dc_k` samples.
- `hold_ms`, 100: clip indicator hold time.
- `decay_us`, 1000: peak meter decay tick period.
- `w_led`, 8: level meter LED count.
- `w_cnt`, 16: clip counter width.

Ports:

- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low (low = reset).
- `mic` in `w_in`: signed input sample.
- `mic_valid` in 1: one-cycle strobe; `mic` is captured when high.
- `gain` in `w_gain`: window select; values above `max_gain` are clamped to `max_gain`.
- `dc_en` in 1: enables DC removal.
- `cnt_clr` in 1: synchronous clear of `clip_cnt`.
- `out` out `w_out`: conditioned signed sample.
- `out_valid` out 1: one-cycle strobe accompanying `out`.
- `clip` out 1: high with `out_valid` when the sample saturated.
- `clip_led` out 1: stretched clip indicator.
- `clip_cnt` out `w_cnt`: saturating count of clipped samples.
- `level_led` out `w_led`: thermometer peak meter.

## Operation

Stage 1 registers, updated only when `mic_valid` is high:

- Width and DC estimate:
  - `c` is `w_in+1` bits.
  - `dc = acc >>> dc_k`, where `acc` is a signed accumulator of `w_in+dc_k+1` bits.
- When `dc_en` = 1: `c = sext(mic) - dc`, then `acc <= acc + sext(c)`.
- When `dc_en` = 0: `c = sext(mic)` and `acc <= 0`.
- `v1 <= mic_valid` every cycle.

Stage 2 registers, updated when `v1` is high:

- `g = min(gain, max_gain)`.
- The output window is `c[w_in-1-g -: w_out]`.
- Guard bits `c[w_in : w_in-1-g]`:
  - all equal: `out` is the window contents and `clip` = 0;
  - not all equal: `out` saturates to +(2^(`w_out`-1) - 1) if `c[w_in]` = 0, else -2^(`w_out`-1), and `clip` = 1.
- `gain` is sampled at stage 2. A change takes effect on the next sample leaving stage 1.

Clip logic:

- `clip_led`:
  - A down-counter is loaded with `hold_cyc = clk_mhz*1000*hold_ms` on every clipped output and is retriggerable.
  - `clip_led` is high while the counter is nonzero.
- `clip_cnt`:
  - increments on each clipped output and saturates at all-ones;
  - `cnt_clr` wins over a simultaneous increment, giving 0.

Peak meter:

- `mag` is |`out`|, clamped to 2^(`w_out`-1) - 1 so that -2^(`w_out`-1) fits.
- A tick occurs every `decay_cyc = clk_mhz*decay_us` cycles, from a free-running counter.
- On a tick: `peak <= peak - ((peak >> 3) | 1)` if `peak` != 0, else 0.
- On a stage-2 output, `peak` is the maximum of `mag` and the (possibly decayed) `peak`. When a tick and an output coincide, decay is applied first, then the max.
- `level_led[i] = (peak >= thr_i)`, where `thr_i = ((i+1) * 2^(w_out-1)) / (w_led+1)`, an elaboration-time constant.

Reset (`rst` low, at any time, including mid-pipeline):

- All outputs, `acc`, `peak`, `v1`, the hold counter and the tick counter go to 0.
- In-flight samples are dropped.

## Timing

- Latency: `out_valid` is asserted exactly 2 clocks after a `mic_valid` strobe.
- Throughput: one sample per clock; back-to-back `mic_valid` is legal.
- `out` and `clip` hold their values between strobes; `clip` updates only on `out_valid`.
- `clip_led` rises 1 clock after `clip`/`out_valid` (registered hold counter). It falls `hold_cyc` clocks after the last clip.
- `clip_cnt` updates on the clock after a clipped `out_valid`.
- `level_led` updates 1 clock after `peak` changes.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan

All scenarios use the defaults unless noted, with `dc_en` = 0.

1. Normal window:
   - Stimulus: `gain` = 6, `mic` = 1152 strobed once.
   - Required: `out` = 9 with `out_valid` exactly 2 clocks later, `clip` = 0, `clip_cnt` = 0.
2. Saturation:
   - Stimulus: `gain` = 6; `mic` = 262144, then `mic` = -262145.
   - Required: `out` = +1023 then -1024, both with `clip` = 1; `clip_cnt` = 2; `clip_led` high.
   - Also required: with `clk_mhz` = 1 and `hold_ms` = 1, `clip_led` drops 1000 clocks after the second clip; a re-clip at clock 500 extends the hold.
3. Gain extremes:
   - Stimulus: `gain` = 0 with `mic` = 8388607; then `gain` = 15 with `mic` = 1000.
   - Required: the first gives `out` = 1023, `clip` = 0. The second is clamped to gain 13 and gives `out` = 1000.
4. DC removal:
   - Stimulus: `dc_en` = 1, `gain` = 13, constant `mic` = 1000 for 400 strobes.
   - Required: the first `out` = 1000, `out` decreases monotonically, and the final `out` = 0 with `clip` = 0.
   - Also required: dropping `dc_en` makes the next sample `out` = 1000.
5. Meter and counter:
   - Stimulus: one full-scale sample, with `clk_mhz` = 1 and `decay_us` = 10; then `cnt_clr` asserted together with a clipped sample.
   - Required: after the sample, all 8 `level_led` are lit, then they extinguish monotonically to 0. After the `cnt_clr` case, `clip_cnt` = 0.
   - Also required: `clip_cnt` saturates at 65535 under continuous clipping.
6. Reset mid-operation:
   - Stimulus: assert `rst` low one clock after `mic_valid`.
   - Required: no `out_valid` appears; all outputs are 0 within the same cycle and stay 0 until after release.
